// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - word-organised single-port RAM target for a valid/ready memory port
//
// Purpose:
//   Target end of the core's valid/ready memory interface. Accepts a request
//   in IDLE or RESP, optionally inserts LATENCY wait states, then accesses the
//   array on the edge that enters RESP and raises mem_ready for one cycle.
//   Out-of-range accesses complete normally: reads return zero, writes drop.
//
// Parameters:
//   DEPTH_LOG2 - log2 of the number of 32-bit words
//   BASE_ADDR  - byte address of word 0, aligned to 4*2^DEPTH_LOG2
//   LATENCY    - wait-state cycles between acceptance and mem_ready (0..15)
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   mem_valid  - request strobe from the initiator
//   mem_instr  - 1 = instruction fetch (writes with this set are dropped)
//   mem_addr   - byte address, bits [1:0] ignored
//   mem_wdata  - write data
//   mem_wstrb  - byte enables, 4'b0000 = read
//   mem_rdata  - read data, non-zero only while mem_ready=1
//   mem_ready  - one-cycle completion pulse

module sram_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] LOAD_CNT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_instr;
    logic [31:0] r_rdata;

    logic [31:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_commit;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wstrb;
    logic                  w_instr;
    logic [31:0]           w_off;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_mem_we;
    logic                  w_mem_re;
    logic [1:0]            w_unused_off;

    // Next-state logic. w_commit marks the edge that enters RESP, which is
    // the single point where the array is read or written.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_commit     = 1'b0;
        w_accept     = mem_valid && (r_state != ST_WAIT);
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_next_state = ST_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = LOAD_CNT;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_next_cnt = r_cnt - 4'd1;
                end else begin
                    w_next_state = ST_RESP;
                    w_commit     = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // A commit out of WAIT uses the captured request; a zero-latency commit
    // happens on the accepting edge itself, so it uses the live inputs.
    always_comb begin
        if (r_state == ST_WAIT) begin
            w_addr  = r_addr;
            w_wdata = r_wdata;
            w_wstrb = r_wstrb;
            w_instr = r_instr;
        end else begin
            w_addr  = mem_addr;
            w_wdata = mem_wdata;
            w_wstrb = mem_wstrb;
            w_instr = mem_instr;
        end
    end

    // Unsigned 32-bit offset: addresses below BASE_ADDR wrap to huge offsets
    // and fall out of range naturally.
    assign w_off        = w_addr - BASE_ADDR;
    assign w_in_range   = (w_off[31:DEPTH_LOG2+2] == '0);
    assign w_idx        = w_off[DEPTH_LOG2+1:2];
    assign w_unused_off = w_off[1:0];

    // Reset at the commit edge abandons the request, so the write is gated.
    assign w_mem_we = w_commit && !rst && w_in_range && (w_wstrb != 4'b0000) && !w_instr;
    assign w_mem_re = w_commit && w_in_range && (w_wstrb == 4'b0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_instr <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_wstrb <= mem_wstrb;
                r_instr <= mem_instr;
            end
            // Cleared on every non-read edge so rdata is zero outside RESP
            // and for writes / out-of-range accesses.
            r_rdata <= w_mem_re ? r_mem[w_idx] : 32'd0;
        end
    end

    // Array has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready = (r_state == ST_RESP);
    assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - self-checking bench for sram_responder
module tb_sram_responder;

    localparam int NU = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_valid [NU];
    logic        d_instr [NU];
    logic [31:0] d_addr  [NU];
    logic [31:0] d_wdata [NU];
    logic [3:0]  d_wstrb [NU];
    logic [31:0] d_rdata [NU];
    logic        d_ready [NU];

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [NU][64];

    always #5 clk = ~clk;

    // Unit 0: 64 words at 0, no wait states.
    sram_responder #(.DEPTH_LOG2(6), .BASE_ADDR(32'h0000_0000), .LATENCY(0)) u_a (
        .clk(clk), .rst(rst),
        .mem_valid(d_valid[0]), .mem_instr(d_instr[0]), .mem_addr(d_addr[0]),
        .mem_wdata(d_wdata[0]), .mem_wstrb(d_wstrb[0]),
        .mem_rdata(d_rdata[0]), .mem_ready(d_ready[0])
    );
    // Unit 1: 16 words at 0x1000, 3 wait states.
    sram_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_1000), .LATENCY(3)) u_b (
        .clk(clk), .rst(rst),
        .mem_valid(d_valid[1]), .mem_instr(d_instr[1]), .mem_addr(d_addr[1]),
        .mem_wdata(d_wdata[1]), .mem_wstrb(d_wstrb[1]),
        .mem_rdata(d_rdata[1]), .mem_ready(d_ready[1])
    );
    // Unit 2: 16 words at 0, 5 wait states.
    sram_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_0000), .LATENCY(5)) u_c (
        .clk(clk), .rst(rst),
        .mem_valid(d_valid[2]), .mem_instr(d_instr[2]), .mem_addr(d_addr[2]),
        .mem_wdata(d_wdata[2]), .mem_wstrb(d_wstrb[2]),
        .mem_rdata(d_rdata[2]), .mem_ready(d_ready[2])
    );

    function automatic logic [31:0] base_of(input int u);
        return (u == 1) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    function automatic int depth_of(input int u);
        return (u == 0) ? 64 : 16;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 0 : ((u == 1) ? 3 : 5);
    endfunction

    // Reference: what a request does to the memory image and what it returns.
    function automatic logic [31:0] model(input int u, input logic [31:0] a,
                                          input logic [31:0] wd, input logic [3:0] ws,
                                          input logic ins);
        logic [31:0] off;
        int          idx;
        off = a - base_of(u);
        if ((off / 4) >= 32'(depth_of(u))) return 32'd0;
        idx = int'(off / 4);
        if (ws == 4'b0000) return mdl[u][idx];
        if (!ins) begin
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) mdl[u][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        return 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    // Called at a negedge: drives a request, waits (bounded) for mem_ready,
    // checks latency and rdata. Returns at the negedge of the ready cycle with
    // valid already low, so the caller may chain a back-to-back request.
    task automatic xact(input int u, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic ins, input logic [31:0] exp,
                        input string nm);
        int n;
        d_valid[u] = 1'b1;
        d_addr[u]  = a;
        d_wdata[u] = wd;
        d_wstrb[u] = ws;
        d_instr[u] = ins;
        @(negedge clk);
        d_valid[u] = 1'b0;
        n = 1;
        while (!d_ready[u] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(1 + lat_of(u)));
        chk({nm, "_rdata"}, d_rdata[u], exp);
    endtask

    typedef struct {
        int          u;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vt [16];

    initial begin
        logic [31:0] a, wd, ex;
        logic [3:0]  ws;
        logic        ins;
        int          u, gap;
        bit          seen;

        for (int i = 0; i < NU; i++) begin
            d_valid[i] = 1'b0; d_instr[i] = 1'b0; d_addr[i] = '0;
            d_wdata[i] = '0;   d_wstrb[i] = '0;
        end

        vt[0]  = '{0, 32'h20,   32'h11223344, 4'hF, 1'b0, 32'h0,        "bs_preload"};
        vt[1]  = '{0, 32'h20,   32'hAABBCCDD, 4'h5, 1'b0, 32'h0,        "bs_write"};
        vt[2]  = '{0, 32'h20,   32'h0,        4'h0, 1'b0, 32'h11BB33DD, "bs_read"};
        vt[3]  = '{0, 32'h20,   32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        "instr_write"};
        vt[4]  = '{0, 32'h22,   32'h0,        4'h0, 1'b0, 32'h11BB33DD, "misalign_read"};
        vt[5]  = '{1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        "oor_w0"};
        vt[6]  = '{1, 32'h1040, 32'h00000055, 4'hF, 1'b0, 32'h0,        "oor_write"};
        vt[7]  = '{1, 32'h1040, 32'h0,        4'h0, 1'b0, 32'h0,        "oor_read"};
        vt[8]  = '{1, 32'h1000, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D, "oor_w0_kept"};
        vt[9]  = '{1, 32'h0FFC, 32'h0,        4'h0, 1'b0, 32'h0,        "below_read"};
        vt[10] = '{1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        "below_write"};
        vt[11] = '{1, 32'h1003, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D, "w0_after_below"};
        vt[12] = '{1, 32'h103C, 32'h01020304, 4'hF, 1'b0, 32'h0,        "top_write"};
        vt[13] = '{1, 32'h103C, 32'h0,        4'h0, 1'b0, 32'h01020304, "top_read"};
        vt[14] = '{2, 32'h0,    32'hA5A5A5A5, 4'hF, 1'b0, 32'h0,        "c_write"};
        vt[15] = '{2, 32'h0,    32'h0,        4'h0, 1'b0, 32'hA5A5A5A5, "c_read"};

        // Reset held with valid high: no response.
        d_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 32'(d_ready[0]), 32'd0);
            chk("rst_rdata", d_rdata[0], 32'd0);
        end
        rst = 1'b0;
        d_valid[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(d_ready[0]), 32'd0);
            chk("post_rst_rdata", d_rdata[0], 32'd0);
        end

        foreach (vt[i]) begin
            xact(vt[i].u, vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].instr, vt[i].exp, vt[i].nm);
        end

        // Back-to-back write then read at LATENCY=0.
        d_valid[0] = 1'b1; d_addr[0] = 32'h10; d_wdata[0] = 32'hDEADBEEF;
        d_wstrb[0] = 4'hF; d_instr[0] = 1'b0;
        @(negedge clk);
        chk("b2b_w_ready", 32'(d_ready[0]), 32'd1);
        chk("b2b_w_rdata", d_rdata[0], 32'd0);
        d_wstrb[0] = 4'h0;
        @(negedge clk);
        chk("b2b_r_ready", 32'(d_ready[0]), 32'd1);
        chk("b2b_r_rdata", d_rdata[0], 32'hDEADBEEF);
        d_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_idle_ready", 32'(d_ready[0]), 32'd0);
        chk("b2b_idle_rdata", d_rdata[0], 32'd0);

        // LATENCY=3 with valid toggled during the wait: one response only.
        d_valid[1] = 1'b1; d_addr[1] = 32'h1000; d_wstrb[1] = 4'h0; d_instr[1] = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk("wait_no_ready", 32'(d_ready[1]), 32'd0);
            d_valid[1] = n[0];
            d_wstrb[1] = 4'hF;
            d_wdata[1] = 32'h0BAD0BAD;
        end
        @(negedge clk);
        d_valid[1] = 1'b0;
        chk("wait_ready", 32'(d_ready[1]), 32'd1);
        chk("wait_rdata", d_rdata[1], 32'hCAFEF00D);
        repeat (3) begin
            @(negedge clk);
            chk("wait_single_pulse", 32'(d_ready[1]), 32'd0);
        end
        xact(1, 32'h1000, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, "wait_ignored_writes");

        // LATENCY=5 write aborted by reset in its second wait cycle.
        d_valid[2] = 1'b1; d_addr[2] = 32'h0; d_wdata[2] = 32'h12345678;
        d_wstrb[2] = 4'hF; d_instr[2] = 1'b0;
        @(negedge clk);
        d_valid[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (d_ready[2]) seen = 1'b1;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        xact(2, 32'h0, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5, "abort_old_value");

        // Randomised traffic against the reference model.
        for (int uu = 0; uu < 2; uu++) begin
            for (int w = 0; w < depth_of(uu); w++) begin
                a  = base_of(uu) + 32'(4 * w);
                wd = $urandom;
                ex = model(uu, a, wd, 4'hF, 1'b0);
                xact(uu, a, wd, 4'hF, 1'b0, ex, "preload");
            end
        end
        for (int i = 0; i < 600; i++) begin
            u   = int'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            if (u == 0) a = 32'($urandom_range(0, 32'h13F));
            else        a = 32'h0FC0 + 32'($urandom_range(0, 32'hBF));
            wd  = $urandom;
            ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ins = ($urandom_range(0, 7) == 0);
            ex  = model(u, a, wd, ws, ins);
            xact(u, a, wd, ws, ins, ex, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
